// File: rtl/legv8_program_loader_pkg.sv
// Shared definitions for the LEGv8 program loader: format/error codes, FSM states,
// symbolic instruction fields and immediate range helpers.
package legv8_program_loader_pkg;

  typedef enum logic [2:0] {
    FmtR    = 3'b000,
    FmtI    = 3'b001,
    FmtD    = 3'b010,
    FmtB    = 3'b011,
    FmtCb   = 3'b100,
    FmtIw   = 3'b101,
    FmtHalt = 3'b110,
    FmtInv  = 3'b111
  } fmt_e;

  typedef enum logic [1:0] {
    ErrNone   = 2'b00,
    ErrRange  = 2'b01,
    ErrClass  = 2'b10,
    ErrFormat = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    StIdle,
    StEnc,
    StWrite,
    StDone,
    StErr
  } state_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [10:0] opc;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [5:0]  shamt;
    logic [1:0]  hw;
    logic [31:0] imm;
  } fields_t;

  localparam int unsigned ImmWidthI  = 12;
  localparam int unsigned ImmWidthD  = 9;
  localparam int unsigned ImmWidthB  = 26;
  localparam int unsigned ImmWidthCb = 19;
  localparam int unsigned ImmWidthIw = 16;

  // Class bits of the packed IR, matched against IR[27:25] (R) or IR[28:26] (I/IW, B/CB).
  localparam logic [2:0] ClassR   = 3'b101;
  localparam logic [2:0] ClassIIw = 3'b100;
  localparam logic [2:0] ClassBCb = 3'b101;

  function automatic logic fits_unsigned(logic [31:0] imm, int unsigned width);
    return (imm >> width) == 32'd0;
  endfunction

  // A signed value fits iff everything above its sign bit is a copy of the sign bit.
  function automatic logic fits_signed(logic [31:0] imm, int unsigned width);
    logic [31:0] hi;
    hi = $signed(imm) >>> (width - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/legv8_program_loader_if.sv
// Instruction-field handshake plus imem write port of the program loader.
interface legv8_program_loader_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [10:0]       in_opc;
  logic [4:0]        in_rd;
  logic [4:0]        in_rn;
  logic [4:0]        in_rm;
  logic [5:0]        in_shamt;
  logic [1:0]        in_hw;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;

  // Boot source and imem side.
  modport master (
    output in_valid, in_fmt, in_opc, in_rd, in_rn, in_rm, in_shamt, in_hw, in_imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  in_valid, in_fmt, in_opc, in_rd, in_rn, in_rm, in_shamt, in_hw, in_imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/legv8_program_loader_field_packer.sv
// Combinational LEGv8 instruction packer with immediate range and opcode class checks.
module legv8_program_loader_field_packer
  import legv8_program_loader_pkg::*;
#(
  parameter bit CHECK_CLASS = 1'b1
) (
  input  fields_t     fields,
  output logic [31:0] word,
  output err_e        err
);

  logic range_ok;
  logic class_ok;

  always_comb begin
    word     = '0;
    range_ok = 1'b1;
    class_ok = 1'b1;
    unique case (fields.fmt)
      FmtR: begin
        word     = {fields.opc, fields.rm, fields.shamt, fields.rn, fields.rd};
        class_ok = (word[27:25] == ClassR);
      end
      FmtI: begin
        word     = {fields.opc[10:1], fields.imm[11:0], fields.rn, fields.rd};
        range_ok = fits_unsigned(fields.imm, ImmWidthI);
        class_ok = (word[28:26] == ClassIIw);
      end
      FmtD: begin
        word     = {fields.opc, fields.imm[8:0], 2'b00, fields.rn, fields.rd};
        range_ok = fits_signed(fields.imm, ImmWidthD);
        class_ok = word[27] && !word[25];
      end
      FmtB: begin
        word     = {fields.opc[10:5], fields.imm[25:0]};
        range_ok = fits_signed(fields.imm, ImmWidthB);
        class_ok = (word[28:26] == ClassBCb);
      end
      FmtCb: begin
        word     = {fields.opc[10:3], fields.imm[18:0], fields.rd};
        range_ok = fits_signed(fields.imm, ImmWidthCb);
        class_ok = (word[28:26] == ClassBCb);
      end
      FmtIw: begin
        word     = {fields.opc[10:2], fields.hw, fields.imm[15:0], fields.rd};
        range_ok = fits_unsigned(fields.imm, ImmWidthIw);
        class_ok = (word[28:26] == ClassIIw);
      end
      FmtHalt, FmtInv: begin
        word = '0;
      end
    endcase

    // Priority: invalid format > class mismatch > range.
    if (fields.fmt == FmtInv) begin
      err = ErrFormat;
    end else if (CHECK_CLASS && !class_ok) begin
      err = ErrClass;
    end else if (!range_ok) begin
      err = ErrRange;
    end else begin
      err = ErrNone;
    end
  end

endmodule

// File: rtl/legv8_program_loader.sv
// LEGv8 program loader: accepts symbolic instructions, packs/checks them and writes them
// sequentially into instruction memory starting at BASE_ADDR.
module legv8_program_loader
  import legv8_program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned BASE_ADDR   = 0,
  parameter bit          CHECK_CLASS = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  legv8_program_loader_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic [1:0]        err
);

  localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W:0]   DepthCnt = DEPTH[ADDR_W:0];

  state_e            state_q;
  fields_t           fields_q;
  fields_t           in_fields;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_inc;
  logic              done_q;
  logic              full_q;
  err_e              err_q;
  logic [31:0]       pack_word;
  err_e              pack_err;

  always_comb begin
    in_fields.fmt   = fmt_e'(bus.in_fmt);
    in_fields.opc   = bus.in_opc;
    in_fields.rd    = bus.in_rd;
    in_fields.rn    = bus.in_rn;
    in_fields.rm    = bus.in_rm;
    in_fields.shamt = bus.in_shamt;
    in_fields.hw    = bus.in_hw;
    in_fields.imm   = bus.in_imm;
  end

  legv8_program_loader_field_packer #(
    .CHECK_CLASS (CHECK_CLASS)
  ) u_packer (
    .fields (fields_q),
    .word   (pack_word),
    .err    (pack_err)
  );

  assign count_inc = count_q + {{ADDR_W{1'b0}}, 1'b1};

  // start behaves as a soft reset and wins over any handshake, including a pending write.
  always_ff @(posedge clock) begin
    if (reset || start) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BaseAddr;
      mem_wdata_q <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      err_q       <= ErrNone;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            fields_q <= in_fields;
            if (in_fields.fmt == FmtHalt) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StEnc;
            end
          end
        end
        StEnc: begin
          if (pack_err != ErrNone) begin
            err_q   <= pack_err;
            state_q <= StErr;
          end else begin
            mem_wdata_q <= pack_word;
            mem_we_q    <= 1'b1;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          if (bus.mem_ack) begin
            mem_we_q <= 1'b0;
            count_q  <= count_inc;
            // Address stays on the last word when full so it never leaves the window.
            if (count_inc == DepthCnt) begin
              done_q  <= 1'b1;
              full_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              mem_addr_q <= mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
              state_q    <= StIdle;
            end
          end
        end
        StDone, StErr: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !start;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign done          = done_q;
  assign full          = full_q;
  assign err           = err_q;

endmodule

// File: tb/tb_legv8_program_loader.sv
// Self-checking bench for legv8_program_loader: directed spec cases plus randomized instructions
// against an arithmetic reference model; a second DEPTH=4 instance covers the full condition.
module tb_legv8_program_loader;
  import legv8_program_loader_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  legv8_program_loader_if #(.ADDR_W(8)) bus0 ();
  legv8_program_loader_if #(.ADDR_W(8)) bus4 ();

  logic       start0, start4;
  logic [8:0] count0, count4;
  logic       done0, done4, full0, full4;
  logic [1:0] err0, err4;

  legv8_program_loader #(
    .ADDR_W(8), .DEPTH(256), .BASE_ADDR(0), .CHECK_CLASS(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start0), .bus(bus0),
    .count(count0), .done(done0), .full(full0), .err(err0)
  );

  legv8_program_loader #(
    .ADDR_W(8), .DEPTH(4), .BASE_ADDR(0), .CHECK_CLASS(1'b1)
  ) dut4 (
    .clock(clock), .reset(reset), .start(start4), .bus(bus4),
    .count(count4), .done(done4), .full(full4), .err(err4)
  );

  // Common driver; sel picks which instance sees valid/ack/start and is observed.
  logic        sel = 1'b0;
  logic        drv_valid = 1'b0, drv_ack = 1'b0, drv_start = 1'b0;
  logic [2:0]  drv_fmt = '0;
  logic [10:0] drv_opc = '0;
  logic [4:0]  drv_rd = '0, drv_rn = '0, drv_rm = '0;
  logic [5:0]  drv_shamt = '0;
  logic [1:0]  drv_hw = '0;
  logic [31:0] drv_imm = '0;

  assign bus0.in_valid = drv_valid & ~sel;
  assign bus4.in_valid = drv_valid & sel;
  assign bus0.mem_ack  = drv_ack & ~sel;
  assign bus4.mem_ack  = drv_ack & sel;
  assign start0        = drv_start & ~sel;
  assign start4        = drv_start & sel;
  assign bus0.in_fmt = drv_fmt;  assign bus4.in_fmt = drv_fmt;
  assign bus0.in_opc = drv_opc;  assign bus4.in_opc = drv_opc;
  assign bus0.in_rd  = drv_rd;   assign bus4.in_rd  = drv_rd;
  assign bus0.in_rn  = drv_rn;   assign bus4.in_rn  = drv_rn;
  assign bus0.in_rm  = drv_rm;   assign bus4.in_rm  = drv_rm;
  assign bus0.in_shamt = drv_shamt; assign bus4.in_shamt = drv_shamt;
  assign bus0.in_hw  = drv_hw;   assign bus4.in_hw  = drv_hw;
  assign bus0.in_imm = drv_imm;  assign bus4.in_imm = drv_imm;

  logic        obs_ready, obs_we, obs_done, obs_full;
  logic [7:0]  obs_addr;
  logic [31:0] obs_wdata;
  logic [8:0]  obs_count;
  logic [1:0]  obs_err;
  assign obs_ready = sel ? bus4.in_ready  : bus0.in_ready;
  assign obs_we    = sel ? bus4.mem_we    : bus0.mem_we;
  assign obs_addr  = sel ? bus4.mem_addr  : bus0.mem_addr;
  assign obs_wdata = sel ? bus4.mem_wdata : bus0.mem_wdata;
  assign obs_count = sel ? count4 : count0;
  assign obs_done  = sel ? done4  : done0;
  assign obs_full  = sel ? full4  : full0;
  assign obs_err   = sel ? err4   : err0;

  int m_count = 0;
  int m_depth = 256;
  int m_base  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference: field placement by arithmetic weights, range by signed integer bounds,
  // class by reading bit groups of the resulting word numerically.
  function automatic void model(input logic [2:0] fmt, input logic [10:0] opc,
                                input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                                input logic [5:0] shamt, input logic [1:0] hw,
                                input logic [31:0] imm, output logic [31:0] w,
                                output logic [1:0] e);
    longint unsigned x, op, u;
    longint          s;
    bit              rng, cls;
    op = opc; u = imm; s = $signed(imm);
    x = 0; rng = 1'b1; cls = 1'b1;
    case (fmt)
      3'd0: begin
        x = op * 2**21 + rm * 2**16 + shamt * 2**10 + rn * 32 + rd;
        cls = ((x / 2**25) % 8) == 5;
      end
      3'd1: begin
        x = (op / 2) * 2**22 + (u % 4096) * 1024 + rn * 32 + rd;
        rng = (s >= 0) && (s <= 4095);
        cls = ((x / 2**26) % 8) == 4;
      end
      3'd2: begin
        x = op * 2**21 + (u % 512) * 4096 + rn * 32 + rd;
        rng = (s >= -256) && (s <= 255);
        cls = ((x / 2**27) % 2 == 1) && ((x / 2**25) % 2 == 0);
      end
      3'd3: begin
        x = (op / 32) * 2**26 + u % 2**26;
        rng = (s >= -(2**25)) && (s < 2**25);
        cls = ((x / 2**26) % 8) == 5;
      end
      3'd4: begin
        x = (op / 8) * 2**24 + (u % 2**19) * 32 + rd;
        rng = (s >= -(2**18)) && (s < 2**18);
        cls = ((x / 2**26) % 8) == 5;
      end
      3'd5: begin
        x = (op / 4) * 2**23 + hw * 2**21 + (u % 65536) * 32 + rd;
        rng = (s >= 0) && (s <= 65535);
        cls = ((x / 2**26) % 8) == 4;
      end
      default: ;
    endcase
    w = x[31:0];
    if (fmt == 3'd7) e = 2'b11;
    else if (!cls)   e = 2'b10;
    else if (!rng)   e = 2'b01;
    else             e = 2'b00;
  endfunction

  // One instruction through the loader; golden (if has_golden) overrides the model word.
  task automatic send(input logic [2:0] fmt, input logic [10:0] opc, input logic [4:0] rd,
                      input logic [4:0] rn, input logic [4:0] rm, input logic [5:0] shamt,
                      input logic [1:0] hw, input logic [31:0] imm, input int stall,
                      input bit has_golden, input logic [31:0] golden, output logic [1:0] e);
    logic [31:0] w;
    model(fmt, opc, rd, rn, rm, shamt, hw, imm, w, e);
    if (has_golden) w = golden;
    drv_fmt = fmt; drv_opc = opc; drv_rd = rd; drv_rn = rn; drv_rm = rm;
    drv_shamt = shamt; drv_hw = hw; drv_imm = imm; drv_valid = 1'b1;
    check("in_ready_idle", obs_ready, 1);
    step();
    drv_valid = 1'b0;
    check("we_enc", obs_we, 0);
    step();
    if (e != 2'b00) begin
      check("err_code", obs_err, e);
      check("we_on_err", obs_we, 0);
      check("ready_on_err", obs_ready, 0);
      step();
      check("we_err_hold", obs_we, 0);
      check("err_hold", obs_err, e);
      check("count_err", obs_count, m_count);
    end else begin
      check("we_t2", obs_we, 1);
      check("addr", obs_addr, m_base + m_count);
      check("wdata", obs_wdata, w);
      for (int i = 0; i < stall; i++) begin
        step();
        check("we_stall", obs_we, 1);
        check("addr_stall", obs_addr, m_base + m_count);
        check("wdata_stall", obs_wdata, w);
      end
      drv_ack = 1'b1;
      step();
      drv_ack = 1'b0;
      m_count++;
      check("we_after_ack", obs_we, 0);
      check("count", obs_count, m_count);
      if (m_count == m_depth) begin
        check("done_full", {obs_done, obs_full}, 2'b11);
        check("ready_full", obs_ready, 0);
        check("addr_full", obs_addr, m_base + m_depth - 1);
      end else begin
        check("ready_next", obs_ready, 1);
        check("done_next", obs_done, 0);
        check("addr_next", obs_addr, m_base + m_count);
      end
    end
  endtask

  task automatic do_start();
    drv_start = 1'b1;
    #1;
    check("ready_during_start", obs_ready, 0);
    @(posedge clock);
    #1;
    drv_start = 1'b0;
    #1;
    m_count = 0;
    check("start_ready", obs_ready, 1);
    check("start_we", obs_we, 0);
    check("start_count", obs_count, 0);
    check("start_flags", {obs_done, obs_full, obs_err}, 4'b0000);
    check("start_addr", obs_addr, m_base);
  endtask

  logic [10:0] legal_opc [6][2] = '{
    '{11'h458, 11'h658}, '{11'h488, 11'h688}, '{11'h7C2, 11'h7C0},
    '{11'h0A0, 11'h4A0}, '{11'h5A0, 11'h5A8}, '{11'h694, 11'h694}
  };

  initial begin
    logic [1:0]  e;
    logic [2:0]  fmt;
    logic [10:0] opc;
    logic [31:0] imm;
    int          lo, hi, k;

    repeat (3) step();
    reset = 1'b0;
    #1;
    check("rst_ready", obs_ready, 1);
    check("rst_we", obs_we, 0);
    check("rst_addr", obs_addr, 0);
    check("rst_wdata", obs_wdata, 0);
    check("rst_count", obs_count, 0);
    check("rst_flags", {obs_done, obs_full, obs_err}, 4'b0000);

    // ADDI then LDUR with negative offset.
    send(3'd1, 11'h488, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'd5, 0, 1'b1, 32'h91001441, e);
    send(3'd2, 11'h7C2, 5'd4, 5'd5, 5'd0, 6'd0, 2'd0, -32'sd256, 1, 1'b1, 32'hF85000A4, e);

    // ADD, B -1, then HALT: nothing further written.
    do_start();
    send(3'd0, 11'h458, 5'd3, 5'd1, 5'd2, 6'd0, 2'd0, 32'd0, 0, 1'b1, 32'h8B020023, e);
    send(3'd3, 11'h0A0, 5'd0, 5'd0, 5'd0, 6'd0, 2'd0, 32'hFFFF_FFFF, 0, 1'b1, 32'h17FFFFFF, e);
    drv_fmt = 3'd6; drv_valid = 1'b1;
    step();
    check("halt_flags", {obs_done, obs_full}, 2'b10);
    check("halt_count", obs_count, 2);
    check("halt_ready", obs_ready, 0);
    drv_fmt = 3'd0;
    repeat (3) begin
      step();
      check("halt_no_write", obs_we, 0);
    end
    drv_valid = 1'b0;
    check("halt_count_hold", obs_count, 2);

    // Error cases and priority.
    do_start();
    send(3'd2, 11'h7C2, 5'd1, 5'd1, 5'd0, 6'd0, 2'd0, 32'd256, 0, 1'b0, 32'h0, e);
    check("model_d_range", e, 2'b01);
    do_start();
    send(3'd1, 11'h458, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'd5000, 0, 1'b0, 32'h0, e);
    check("model_class", e, 2'b10);
    do_start();
    send(3'd7, 11'h458, 5'd1, 5'd2, 5'd0, 6'd0, 2'd0, 32'd0, 0, 1'b0, 32'h0, e);
    do_start();

    // Write stall, then start aborts a pending write.
    send(3'd5, 11'h694, 5'd7, 5'd0, 5'd0, 6'd0, 2'd3, 32'd65535, 3, 1'b0, 32'h0, e);
    drv_fmt = 3'd1; drv_opc = 11'h488; drv_imm = 32'd9; drv_valid = 1'b1;
    step();
    drv_valid = 1'b0;
    step();
    check("abort_we", obs_we, 1);
    repeat (2) step();
    check("abort_we_held", obs_we, 1);
    do_start();

    // Randomized instructions.
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 15);
      fmt = (k == 15) ? 3'd7 : 3'(k % 6);
      opc = ($urandom_range(0, 3) == 0) ? 11'($urandom) : legal_opc[fmt % 6][$urandom_range(0, 1)];
      case (fmt)
        3'd1: begin lo = 0; hi = 4095; end
        3'd2: begin lo = -256; hi = 255; end
        3'd3: begin lo = -(2**25); hi = 2**25 - 1; end
        3'd4: begin lo = -(2**18); hi = 2**18 - 1; end
        3'd5: begin lo = 0; hi = 65535; end
        default: begin lo = 0; hi = 0; end
      endcase
      k = $urandom_range(0, 7);
      if (fmt == 3'd0 || fmt == 3'd7) imm = $urandom;
      else if (k == 0) imm = 32'(hi + 1);
      else if (k == 1) imm = 32'(lo - 1);
      else imm = 32'(lo + int'($urandom_range(0, 32'(hi - lo))));
      send(fmt, opc, 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom), 2'($urandom),
           imm, int'($urandom_range(0, 3)), 1'b0, 32'h0, e);
      if (e != 2'b00) do_start();
    end

    // DEPTH=4 instance: four writes fill it, a fifth is never taken.
    sel = 1'b1;
    m_depth = 4;
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 11'h458, 5'(i), 5'd1, 5'd2, 6'd0, 2'd0, 32'd0, i % 2, 1'b0, 32'h0, e);
    end
    drv_fmt = 3'd0; drv_valid = 1'b1;
    repeat (4) begin
      step();
      check("full_no_write", obs_we, 0);
      check("full_ready", obs_ready, 0);
    end
    drv_valid = 1'b0;
    check("full_count", obs_count, 4);
    check("full_addr", obs_addr, 3);
    do_start();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
